// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory bus between the MEM stage and data memory
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage: aligned loads/stores over a req/ack bus
// with lane steering, misalignment trap and bus timeout.
module mem_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_mem_size,
  input  logic        ex_mem_unsigned,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_store_data,
  input  logic [9:0]  ex_wb,
  mem_stage_if.master dmem,
  output logic        mem_stall,
  output logic        mem_wb_valid,
  output logic [31:0] mem_wb_data,
  output logic [9:0]  mem_wb_wb,
  output logic        mem_wb_misalign,
  output logic        mem_wb_buserr
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          cap_store;
  logic          cap_unsigned;
  logic [1:0]    cap_size;
  logic [31:0]   cap_addr;
  logic [9:0]    cap_wb;

  logic mem_op, misalign, start, timeout;

  assign mem_op   = ex_valid & (ex_mem_read | ex_mem_write);
  assign misalign = ((ex_mem_size == 2'b01) & ex_addr[0]) |
                    (ex_mem_size[1] & (|ex_addr[1:0]));

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Little-endian: shift the addressed lane down to bit 0, then extend.
  function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] a,
                                               input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    sh = rdata >> {a, 3'b000};
    case (size)
      2'b00:   return uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   return uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return rdata;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    timeout    = 1'b0;
    mem_stall  = 1'b0;
    case (state)
      IDLE: begin
        start     = mem_op & ~misalign;
        mem_stall = start;
        if (start) state_next = BUSY;
      end
      BUSY: begin
        timeout   = ~dmem.dmem_ack & (cnt == CNT_LAST);
        mem_stall = ~dmem.dmem_ack & ~timeout;
        if (dmem.dmem_ack | timeout) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (rst) mem_stall = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_be    <= '0;
      dmem.dmem_wdata <= '0;
      mem_wb_valid    <= 1'b0;
      mem_wb_data     <= '0;
      mem_wb_wb       <= '0;
      mem_wb_misalign <= 1'b0;
      mem_wb_buserr   <= 1'b0;
      cnt             <= '0;
      cap_store       <= 1'b0;
      cap_unsigned    <= 1'b0;
      cap_size        <= '0;
      cap_addr        <= '0;
      cap_wb          <= '0;
    end else begin
      mem_wb_valid    <= 1'b0;
      mem_wb_wb       <= '0;
      mem_wb_misalign <= 1'b0;
      mem_wb_buserr   <= 1'b0;
      if (state == IDLE) begin
        if (ex_valid && !mem_op) begin
          mem_wb_valid <= 1'b1;
          mem_wb_data  <= ex_addr;
          mem_wb_wb    <= ex_wb;
        end else if (mem_op && misalign) begin
          mem_wb_valid    <= 1'b1;
          mem_wb_misalign <= 1'b1;
          mem_wb_data     <= ex_addr;
        end else if (start) begin
          // A write wins over a simultaneous read: treated purely as a store.
          dmem.dmem_req   <= 1'b1;
          dmem.dmem_we    <= ex_mem_write;
          dmem.dmem_addr  <= {ex_addr[31:2], 2'b00};
          dmem.dmem_be    <= lane_be(ex_mem_size, ex_addr[1:0]);
          dmem.dmem_wdata <= lane_wdata(ex_mem_size, ex_store_data);
          cnt             <= '0;
          cap_store       <= ex_mem_write;
          cap_unsigned    <= ex_mem_unsigned;
          cap_size        <= ex_mem_size;
          cap_addr        <= ex_addr;
          cap_wb          <= ex_wb;
        end
      end else begin
        if (dmem.dmem_ack) begin
          dmem.dmem_req <= 1'b0;
          dmem.dmem_we  <= 1'b0;
          mem_wb_valid  <= 1'b1;
          mem_wb_wb     <= cap_wb;
          mem_wb_data   <= cap_store ? cap_addr
                         : load_extract(dmem.dmem_rdata, cap_addr[1:0], cap_size, cap_unsigned);
        end else if (timeout) begin
          dmem.dmem_req <= 1'b0;
          dmem.dmem_we  <= 1'b0;
          mem_wb_valid  <= 1'b1;
          mem_wb_buserr <= 1'b1;
          mem_wb_data   <= cap_addr;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage: directed loads, stores,
// misaligned traps, bus timeout and reset abort.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_mem_unsigned;
  logic [1:0]  ex_mem_size;
  logic [31:0] ex_addr, ex_store_data;
  logic [9:0]  ex_wb;
  logic        mem_stall, mem_wb_valid, mem_wb_misalign, mem_wb_buserr;
  logic [31:0] mem_wb_data;
  logic [9:0]  mem_wb_wb;

  mem_stage_if bus ();

  mem_stage #(.TIMEOUT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid        (ex_valid),
    .ex_mem_read     (ex_mem_read),
    .ex_mem_write    (ex_mem_write),
    .ex_mem_size     (ex_mem_size),
    .ex_mem_unsigned (ex_mem_unsigned),
    .ex_addr         (ex_addr),
    .ex_store_data   (ex_store_data),
    .ex_wb           (ex_wb),
    .dmem            (bus.master),
    .mem_stall       (mem_stall),
    .mem_wb_valid    (mem_wb_valid),
    .mem_wb_data     (mem_wb_data),
    .mem_wb_wb       (mem_wb_wb),
    .mem_wb_misalign (mem_wb_misalign),
    .mem_wb_buserr   (mem_wb_buserr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [9:0]  wb;
    logic        mis;
    logic        berr;
    bit          chk_data;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] data, input logic [9:0] wb, input logic mis,
                          input logic berr, input bit chk_data, input string name);
    exp_t e;
    e.data = data; e.wb = wb; e.mis = mis; e.berr = berr; e.chk_data = chk_data; e.name = name;
    sb.push_back(e);
  endtask

  // Monitor: every writeback the DUT presents must match the oldest expectation.
  always @(negedge clk) begin
    if (mem_wb_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wb_valid: got data 0x%08h wb 0x%03h, expected no writeback",
                 mem_wb_data, mem_wb_wb);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.chk_data) check({mon_e.name, "_data"}, mem_wb_data, mon_e.data);
        check({mon_e.name, "_wb"}, 32'(mem_wb_wb), 32'(mon_e.wb));
        check({mon_e.name, "_misalign"}, 32'(mem_wb_misalign), 32'(mon_e.mis));
        check({mon_e.name, "_buserr"}, 32'(mem_wb_buserr), 32'(mon_e.berr));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, rd, wr, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, sdata, input logic [9:0] wb);
    ex_valid = v; ex_mem_read = rd; ex_mem_write = wr; ex_mem_size = size;
    ex_mem_unsigned = uns; ex_addr = addr; ex_store_data = sdata; ex_wb = wb;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 10'h0);
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'h0;
  endtask

  task automatic mem_access(input logic rd, wr, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, sdata, input logic [9:0] wb,
                            input int delay, input logic [31:0] rdata, input logic [3:0] be,
                            input logic [31:0] wdata, dat, input string name);
    int stalls = 0;
    step();
    drive(1'b1, rd, wr, size, uns, addr, sdata, wb);
    push_exp(dat, wb, 1'b0, 1'b0, 1'b1, name);
    sample();
    if (mem_stall) stalls++;
    step();
    for (int c = 0; c <= delay; c++) begin
      if (c == delay) begin
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = rdata;
      end
      sample();
      if (c == 0) begin
        check({name, "_addr"}, bus.dmem_addr, {addr[31:2], 2'b00});
        check({name, "_be"}, 32'(bus.dmem_be), 32'(be));
        check({name, "_we"}, 32'(bus.dmem_we), 32'(wr));
        if (wr) check({name, "_wdata"}, bus.dmem_wdata, wdata);
      end
      check({name, "_req"}, 32'(bus.dmem_req), 32'd1);
      if (mem_stall) stalls++;
      step();
    end
    idle_inputs();
    check({name, "_stall_cycles"}, 32'(stalls), 32'(delay + 1));
    sample();
    check({name, "_req_drop"}, 32'(bus.dmem_req), 32'd0);
  endtask

  task automatic misaligned(input logic rd, wr, input logic [1:0] size,
                            input logic [31:0] addr, input logic [9:0] wb, input string name);
    step();
    drive(1'b1, rd, wr, size, 1'b0, addr, 32'h1234_5678, wb);
    push_exp(addr, 10'h0, 1'b1, 1'b0, 1'b1, name);
    sample();
    check({name, "_stall"}, 32'(mem_stall), 32'd0);
    step();
    idle_inputs();
    sample();
    check({name, "_no_req"}, 32'(bus.dmem_req), 32'd0);
  endtask

  task automatic alu(input logic [31:0] addr, input logic [9:0] wb, input logic ack,
                     input string name);
    step();
    drive(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, addr, 32'h0, wb);
    bus.dmem_ack = ack;
    push_exp(addr, wb, 1'b0, 1'b0, 1'b1, name);
    sample();
    check({name, "_stall"}, 32'(mem_stall), 32'd0);
    check({name, "_no_req"}, 32'(bus.dmem_req), 32'd0);
  endtask

  task automatic idle_check(input string name);
    step();
    idle_inputs();
    step();
    step();
    sample();
    check({name, "_valid"}, 32'(mem_wb_valid), 32'd0);
    check({name, "_wb"}, 32'(mem_wb_wb), 32'd0);
  endtask

  task automatic timeout_test();
    int  reqs   = 0;
    int  stalls = 0;
    bit  last   = 0;
    step();
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_8000, 32'h0, 10'h3FF);
    push_exp(32'h0, 10'h0, 1'b0, 1'b1, 1'b0, "timeout");
    sample();
    if (mem_stall) stalls++;
    step();
    for (int i = 0; i < 10; i++) begin
      sample();
      if (!bus.dmem_req) break;
      reqs++;
      if (mem_stall) stalls++;
      else last = 1;
      step();
      if (last) idle_inputs();
    end
    idle_inputs();
    check("timeout_req_cycles", 32'(reqs), 32'd4);
    check("timeout_stall_cycles", 32'(stalls), 32'd4);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, 10'h1);
    #12;
    check("reset_stall", 32'(mem_stall), 32'd0);
    check("reset_req", 32'(bus.dmem_req), 32'd0);
    check("reset_be", 32'(bus.dmem_be), 32'd0);
    check("reset_addr", bus.dmem_addr, 32'h0);
    check("reset_wdata", bus.dmem_wdata, 32'h0);
    check("reset_wb_valid", 32'(mem_wb_valid), 32'd0);
    check("reset_wb_data", mem_wb_data, 32'h0);
    idle_inputs();
    step();
    rst = 1'b0;

    alu(32'h0000_1234, 10'h155, 1'b0, "alu_first");
    //          rd    wr    size   uns   addr          sdata         wb     dly rdata         be       wdata         expected
    mem_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0,        10'h2A1, 3, 32'h80AA_BBCC, 4'b1000, 32'h0,        32'hFFFF_FF80, "ld_byte_1003");
    mem_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 10'h0C3, 0, 32'h0,        4'b1100, 32'hBEEF_BEEF, 32'h0000_2002, "st_half_2002");
    mem_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_4001, 32'h1234_5678, 10'h011, 1, 32'h0,        4'b0010, 32'h7878_7878, 32'h0000_4001, "st_byte_4001");
    mem_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_5002, 32'h0,        10'h022, 2, 32'h80AA_BBCC, 4'b1100, 32'h0,        32'h0000_80AA, "ldu_half_5002");
    mem_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_5000, 32'h0,        10'h033, 0, 32'h80AA_BBCC, 4'b0011, 32'h0,        32'hFFFF_BBCC, "lds_half_5000");
    mem_access(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_6000, 32'h0,        10'h044, 1, 32'hDEAD_BEEF, 4'b1111, 32'h0,        32'hDEAD_BEEF, "ld_size11_6000");
    mem_access(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_7004, 32'hCAFE_F00D, 10'h055, 0, 32'h1111_1111, 4'b1111, 32'hCAFE_F00D, 32'h0000_7004, "rdwr_as_store");

    misaligned(1'b1, 1'b0, 2'b10, 32'h0000_3001, 10'h066, "mis_word_3001");
    misaligned(1'b0, 1'b1, 2'b01, 32'h0000_7001, 10'h077, "mis_half_7001");
    misaligned(1'b1, 1'b0, 2'b11, 32'h0000_6002, 10'h088, "mis_size11_6002");
    idle_check("idle_after_mis");

    timeout_test();
    alu(32'h0000_8888, 10'h099, 1'b0, "alu_after_timeout");
    idle_check("idle_after_timeout");

    step();
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_9000, 32'h0, 10'h111);
    sample();
    step();
    sample();
    check("busy_req_before_rst", 32'(bus.dmem_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_async_req", 32'(bus.dmem_req), 32'd0);
    check("rst_stall", 32'(mem_stall), 32'd0);
    check("rst_wb_valid", 32'(mem_wb_valid), 32'd0);
    idle_inputs();
    step();
    rst = 1'b0;
    alu(32'h0000_A000, 10'h0AA, 1'b0, "alu_post_rst_a");
    alu(32'h0000_A004, 10'h055, 1'b1, "alu_post_rst_b_ack_ignored");
    idle_check("idle_final");

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the maximum number of cycles in BUSY without dmem_ack before a bus error is declared.
REQ-002 SHALL have ports, clock and reset first:
  clk  in  1  clock
  rst  in  1  reset
REQ-003 Reset rst SHALL be asynchronous, active-high; clock clk.
REQ-004 SHALL have upstream inputs from the EX/MEM pipeline register:
  ex_valid  in  1  instruction present
  ex_mem_read  in  1  load
  ex_mem_write  in  1  store
  ex_mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
  ex_mem_unsigned  in  1  zero-extend load
  ex_addr  in  32  ALU result / effective address
  ex_store_data  in  32  store operand
  ex_wb  in  10  opaque writeback control bundle
REQ-005 SHALL have data-memory bus ports:
  dmem_req  out  1
  dmem_we  out  1
  dmem_addr  out  32  word-aligned, bits[1:0]=00
  dmem_be  out  4
  dmem_wdata  out  32
  dmem_ack  in  1
  dmem_rdata  in  32
REQ-006 SHALL have pipeline outputs:
  mem_stall  out  1  hold EX/MEM and earlier stages
  mem_wb_valid  out  1
  mem_wb_data  out  32  load result or ex_addr pass-through
  mem_wb_wb  out  10
  mem_wb_misalign  out  1
  mem_wb_buserr  out  1

Function
REQ-007 SHALL implement FSM states IDLE and BUSY.
REQ-008 Memory op = ex_valid & (ex_mem_read | ex_mem_write). When both read and write are set, the op SHALL be treated as a store and produce no load data.
REQ-009 Misaligned SHALL mean half with addr[0]=1, or word (including size 11) with addr[1:0]!=00.
REQ-010 IDLE, non-memory valid instruction: at the next edge, mem_wb_valid=1, mem_wb_data=ex_addr, mem_wb_wb=ex_wb, flags 0; 1-cycle latency.
REQ-011 IDLE, misaligned memory op: no bus access; at the next edge, mem_wb_valid=1, mem_wb_misalign=1, mem_wb_wb=0, mem_wb_data=ex_addr; no stall.
REQ-012 IDLE, aligned memory op: mem_stall=1 combinationally; at the edge, capture op/address/data/wb and enter BUSY; mem_wb_valid=0 (bubble).
REQ-013 BUSY: dmem_req=1 from a register, with dmem_we/addr/be/wdata held stable from captured values until ack.
REQ-014 mem_stall SHALL equal (IDLE & aligned memory op) | (BUSY & ~dmem_ack); it SHALL be low in the ack cycle so upstream advances on the same edge.
REQ-015 On dmem_ack in BUSY, at the edge: mem_wb_valid=1, mem_wb_wb=captured wb, state=IDLE, dmem_req=0.
  - Load: mem_wb_data = extracted lane.
  - Store: mem_wb_data = captured address.
REQ-016 While stalled in BUSY, mem_wb_valid SHALL be 0 each cycle.
REQ-017 Byte enables SHALL be: byte 0001<<a[1:0]; half 0011<<a[1:0]; word 1111.
REQ-018 dmem_wdata SHALL be: byte replicated x4; half replicated x2; word as-is.
REQ-019 Load extraction SHALL be little-endian, lane selected by a[1:0]; sign-extended unless ex_mem_unsigned=1, in which case zero-extended.
REQ-020 Timeout: a cycle counter SHALL clear on BUSY entry. If the counter reaches TIMEOUT-1 without ack, then at that edge:
  - dmem_req drops and the FSM returns to IDLE.
  - mem_wb_valid=1, mem_wb_buserr=1, mem_wb_wb=0.
  - mem_stall=0 in that cycle.
REQ-021 dmem_ack SHALL be ignored in IDLE.
REQ-022 ex_valid=0 in IDLE SHALL produce mem_wb_valid=0 and mem_wb_wb=0.

Reset
REQ-023 rst SHALL immediately force: state IDLE, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, all mem_wb_* outputs 0, counter 0.
REQ-024 rst asserted during BUSY SHALL abort the access with no writeback produced; after deassertion, the first cycle SHALL behave as IDLE.
REQ-025 mem_stall SHALL be 0 while rst is high.

Verification
REQ-026 Load byte, addr 0x1003, unsigned=0, rdata 0x80AABBCC, ack after 3 cycles -> be=1000, addr 0x1000, stall high 4 cycles, mem_wb_data=0xFFFFFF80, valid 1 cycle.
REQ-027 Store half, addr 0x2002, data 0x0000BEEF, immediate ack -> be=1100, wdata=0xBEEFBEEF, 2-cycle latency, mem_wb_data=0x2002.
REQ-028 Load word, addr 0x3001 -> no dmem_req, mem_wb_misalign=1, mem_wb_wb=0, no stall.
REQ-029 TIMEOUT=4, load with ack never asserted -> req high 4 cycles, then buserr=1, wb=0, FSM IDLE, next instruction accepted.
REQ-030 rst pulsed during BUSY -> dmem_req=0 asynchronously, no mem_wb_valid; back-to-back ALU ops after reset each produce mem_wb_valid with data=ex_addr.
